// File: rtl/lcd_msg_ctrl_pkg.sv
// Shared constants, init sequence and state encodings for the HD44780 message controller.
package lcd_pkg;

  localparam int INIT_LEN = 6;
  // Element 0 is issued first: function set x3, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_ADDR_ROW0 = 8'h80;
  localparam logic [7:0] LCD_ADDR_ROW1 = 8'hC0;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;

  localparam int LCD_COLS  = 16;
  localparam int LCD_ROWS  = 2;
  localparam int FRAME_LEN = LCD_ROWS * (LCD_COLS + 1);

  typedef enum logic [1:0] {TOP_PWRUP, TOP_INIT, TOP_FRAME, TOP_IDLE} top_state_e;
  typedef enum logic [1:0] {BYTE_SETUP, BYTE_EN_HI, BYTE_WAIT} byte_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_msg_ctrl_rom.sv
// Canned status text; unknown message indices read back as blank rows.
module lcd_msg_rom
  import lcd_pkg::*;
#(
  parameter int NUM_MSG = 5,
  parameter int MSG_W   = 3
) (
  input  logic [MSG_W-1:0] msg_i,
  input  logic             row_i,
  input  logic [3:0]       col_i,
  output logic [7:0]       char_o
);

  localparam logic [8*LCD_COLS-1:0] TXT_HUM_OK  = " HUMEDAD: OK    ";
  localparam logic [8*LCD_COLS-1:0] TXT_HUM_LOW = " HUMEDAD: LOW   ";
  localparam logic [8*LCD_COLS-1:0] TXT_LUZ_OK  = " LUZ: OK        ";
  localparam logic [8*LCD_COLS-1:0] TXT_LUZ_LOW = " LUZ: LOW       ";
  localparam logic [8*LCD_COLS-1:0] TXT_WARN    = "     WARNING    ";
  localparam logic [8*LCD_COLS-1:0] TXT_BANG    = "      !!!!      ";
  localparam logic [8*LCD_COLS-1:0] TXT_BLANK   = {LCD_COLS{ASCII_SPACE}};

  logic [8*LCD_COLS-1:0] line;

  always_comb begin
    line = TXT_BLANK;
    if (int'(msg_i) < NUM_MSG) begin
      case (int'(msg_i))
        0:       line = row_i ? TXT_LUZ_OK  : TXT_HUM_OK;
        1:       line = row_i ? TXT_LUZ_LOW : TXT_HUM_OK;
        2:       line = row_i ? TXT_LUZ_OK  : TXT_HUM_LOW;
        3:       line = row_i ? TXT_LUZ_LOW : TXT_HUM_LOW;
        4:       line = row_i ? TXT_BANG    : TXT_WARN;
        default: line = TXT_BLANK;
      endcase
    end
    // Column 0 is the leftmost character, i.e. the most significant byte.
    char_o = line[8*(LCD_COLS-1-int'(col_i)) +: 8];
  end

endmodule

// File: rtl/lcd_msg_ctrl.sv
// HD44780 2x16 controller: power-up wait, init sequence, then redraws the selected
// message only when the selection changes or a refresh is requested.
module lcd_msg_ctrl
  import lcd_pkg::*;
#(
  parameter int NUM_MSG   = 5,
  parameter int PWRUP_CYC = 750000,
  parameter int EN_CYC    = 25,
  parameter int CMD_CYC   = 2500,
  parameter int CLR_CYC   = 100000,
  localparam int MSG_W    = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [MSG_W-1:0] iMSG,
  input  logic             iREFRESH,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic             LCD_EN,
  output logic             oBUSY,
  output logic             oFRAME_DONE
);

  localparam int MAX_CYC = max2(max2(PWRUP_CYC, EN_CYC), max2(CMD_CYC, CLR_CYC));
  localparam int CNT_W   = max2(1, $clog2(MAX_CYC));

  top_state_e        top_q, top_d;
  byte_state_e       bst_q, bst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        idx_q, idx_d;
  logic [MSG_W-1:0]  shown_q, shown_d;
  logic              pend_q, pend_d;
  logic [7:0]        data_q, data_d;
  logic              rs_q, rs_d, en_q, en_d, done_q, done_d, busy_q, busy_d;

  logic [5:0]        nidx;
  logic              rom_row;
  logic [3:0]        rom_col;
  logic [7:0]        rom_char;
  logic [8:0]        next_byte;
  logic [CNT_W-1:0]  wait_last;
  logic              last_byte, frame_start, post_init;

  assign nidx    = idx_q + 6'd1;
  assign rom_row = (nidx > 6'(LCD_COLS + 1));
  assign rom_col = 4'(nidx - (rom_row ? 6'(LCD_COLS + 2) : 6'd1));

  lcd_msg_rom #(.NUM_MSG(NUM_MSG), .MSG_W(MSG_W)) u_rom (
    .msg_i  (shown_q),
    .row_i  (rom_row),
    .col_i  (rom_col),
    .char_o (rom_char)
  );

  assign next_byte   = (top_q == TOP_INIT)             ? {1'b0, INIT_CMDS[nidx[2:0]]} :
                       (nidx == 6'(LCD_COLS + 1))      ? {1'b0, LCD_ADDR_ROW1} :
                                                         {1'b1, rom_char};
  assign wait_last   = (!rs_q && data_q == LCD_CMD_CLEAR) ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
  assign last_byte   = (top_q == TOP_INIT) ? (idx_q == 6'(INIT_LEN - 1)) : (idx_q == 6'(FRAME_LEN - 1));
  assign frame_start = (top_q == TOP_FRAME) && (bst_q == BYTE_SETUP) && (idx_q == 6'd0);
  assign post_init   = (top_q == TOP_FRAME) || (top_q == TOP_IDLE);

  always_comb begin
    top_d   = top_q;
    bst_d   = bst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shown_d = shown_q;
    pend_d  = pend_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    done_d  = 1'b0;
    busy_d  = !(top_q == TOP_IDLE && !pend_q);

    // The frame latches its message here, so later changes only queue a follow-up frame.
    if (frame_start) begin
      shown_d = iMSG;
      pend_d  = iREFRESH;
    end else if (iREFRESH || (post_init && iMSG != shown_q)) begin
      pend_d = 1'b1;
    end

    case (top_q)
      TOP_PWRUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
          top_d  = TOP_INIT;
          bst_d  = BYTE_SETUP;
          cnt_d  = '0;
          idx_d  = '0;
          rs_d   = 1'b0;
          data_d = INIT_CMDS[0];
        end
      end
      TOP_IDLE: begin
        if (pend_q) begin
          top_d  = TOP_FRAME;
          bst_d  = BYTE_SETUP;
          cnt_d  = '0;
          idx_d  = '0;
          rs_d   = 1'b0;
          data_d = LCD_ADDR_ROW0;
        end
      end
      default: begin
        case (bst_q)
          BYTE_SETUP: begin
            bst_d = BYTE_EN_HI;
            en_d  = 1'b1;
            cnt_d = '0;
          end
          BYTE_EN_HI: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(EN_CYC - 1)) begin
              en_d  = 1'b0;
              bst_d = BYTE_WAIT;
              cnt_d = '0;
            end
          end
          default: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == wait_last) begin
              cnt_d = '0;
              if (!last_byte) begin
                idx_d          = nidx;
                bst_d          = BYTE_SETUP;
                {rs_d, data_d} = next_byte;
              end else if (top_q == TOP_INIT) begin
                top_d  = TOP_FRAME;
                bst_d  = BYTE_SETUP;
                idx_d  = '0;
                rs_d   = 1'b0;
                data_d = LCD_ADDR_ROW0;
              end else begin
                top_d  = TOP_IDLE;
                done_d = 1'b1;
              end
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      top_q   <= TOP_PWRUP;
      bst_q   <= BYTE_SETUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      pend_q  <= 1'b1;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      top_q   <= top_d;
      bst_q   <= bst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign LCD_DATA    = data_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = 1'b0;
  assign LCD_EN      = en_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// Bench for lcd_msg_ctrl: expected LCD byte stream queued from a text-level model,
// checked by a monitor on every EN strobe, plus timing and status checks.
module tb_lcd_msg_ctrl;

  localparam int PWRUP_CYC = 20;
  localparam int EN_CYC    = 2;
  localparam int CMD_CYC   = 4;
  localparam int CLR_CYC   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] msg = 3'd0;
  logic       refresh = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, busy, frame_done;

  lcd_msg_ctrl #(
    .NUM_MSG(5), .PWRUP_CYC(PWRUP_CYC), .EN_CYC(EN_CYC), .CMD_CYC(CMD_CYC), .CLR_CYC(CLR_CYC)
  ) dut (
    .iCLK(clk), .iRST(rst), .iMSG(msg), .iREFRESH(refresh),
    .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
    .oBUSY(busy), .oFRAME_DONE(frame_done)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Scoreboard entry: {check gap before this byte, rs, data}
  logic [9:0] exp_q[$];
  logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int act_done = 0;
  int nbytes = 0;
  int first_en_cyc = -1;
  int first_done_cyc = -1;
  int first_busy0_cyc = -1;

  function automatic logic [7:0] ref_char(input int m, input int row, input int col);
    string s;
    s = "";
    if (m == 4) begin
      if (row == 0) s = "     WARNING";
      else          s = "      !!!!";
    end else if (m < 4) begin
      if (row == 0) begin
        if (m >= 2) s = " HUMEDAD: LOW";
        else        s = " HUMEDAD: OK";
      end else begin
        if (m % 2 == 1) s = " LUZ: LOW";
        else            s = " LUZ: OK";
      end
    end
    if (col < s.len()) return s[col];
    return 8'h20;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < 6; i++) exp_q.push_back({(i > 0), 1'b0, init_seq[i]});
  endtask

  task automatic push_frame(input int m, input bit after_init);
    exp_q.push_back({after_init, 1'b0, 8'h80});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, 1'b1, ref_char(m, 0, c)});
    exp_q.push_back({1'b1, 1'b0, 8'hC0});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, 1'b1, ref_char(m, 1, c)});
    exp_done++;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (act_done < exp_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_frames_done"}, act_done, exp_done);
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int n = 0;
    while (!(nbytes >= target && lcd_en) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(nbytes >= target && lcd_en)) begin
      errors++;
      $display("FAIL %s_timeout: bytes seen %0d, required %0d", tag, nbytes, target);
    end
  endtask

  // Monitor: compares each strobed byte, EN width and inter-byte gaps.
  logic       prev_en = 1'b0;
  int         hi_cnt = 0;
  int         lo_cnt = 0;
  logic [8:0] last_exp = '0;
  always @(negedge clk) begin
    logic [9:0] e;
    int gap;
    if (rst) begin
      prev_en = 1'b0;
      hi_cnt = 0;
      lo_cnt = 0;
      first_en_cyc = -1;
      first_done_cyc = -1;
      first_busy0_cyc = -1;
    end else begin
      if (lcd_en && !prev_en) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got rs=%0b data=%h, nothing expected", lcd_rs, lcd_data);
        end else begin
          e = exp_q.pop_front();
          if ({lcd_rs, lcd_data} !== e[8:0]) begin
            errors++;
            $display("FAIL lcd_byte %0d: got rs=%0b data=%h, required rs=%0b data=%h",
                     nbytes, lcd_rs, lcd_data, e[8], e[7:0]);
          end
          if (e[9]) begin
            gap = (last_exp == {1'b0, 8'h01}) ? CLR_CYC + 1 : CMD_CYC + 1;
            check("en_low_gap", lo_cnt, gap);
          end
          last_exp = e[8:0];
        end
        nbytes++;
        hi_cnt = 0;
      end
      if (!lcd_en && prev_en) begin
        check("en_high_width", hi_cnt, EN_CYC);
        lo_cnt = 0;
      end
      if (lcd_en) hi_cnt++;
      else        lo_cnt++;
      if (frame_done) begin
        act_done++;
        if (first_done_cyc < 0) first_done_cyc = cyc;
      end
      if (!busy && first_busy0_cyc < 0) first_busy0_cyc = cyc;
      prev_en = lcd_en;
    end
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 0);
    check("rst_busy", busy, 1);
    check("rst_done", frame_done, 0);

    // Power-up, init and first frame with message 0
    push_init();
    push_frame(0, 1'b1);
    rst = 1'b0;
    wait_done(2000, "s2");
    repeat (3) @(negedge clk);
    check("first_en_cycle", first_en_cyc, PWRUP_CYC + 1);
    check("frame_done_cycle", first_done_cyc, 306);
    check("busy_low_cycle", first_busy0_cyc, 307);
    check("s2_queue_empty", exp_q.size(), 0);

    // Selection change in IDLE
    repeat ($urandom_range(3, 12)) @(negedge clk);
    push_frame(4, 1'b0);
    msg = 3'd4;
    wait_done(1000, "s3");
    repeat (3) @(negedge clk);
    check("s3_busy_idle", busy, 0);

    // Changes mid-frame collapse into one follow-up frame
    repeat ($urandom_range(3, 12)) @(negedge clk);
    push_frame(0, 1'b0);
    msg = 3'd0;
    base = nbytes;
    wait_bytes(base + 6, 1000, "s4");
    msg = 3'd2;
    repeat ($urandom_range(10, 40)) @(negedge clk);
    msg = 3'd3;
    push_frame(3, 1'b0);
    wait_done(2000, "s4");
    repeat (3) @(negedge clk);
    check("s4_busy_idle", busy, 0);
    check("s4_queue_empty", exp_q.size(), 0);

    // Refresh alone, then refresh together with a change
    repeat ($urandom_range(3, 12)) @(negedge clk);
    push_frame(3, 1'b0);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done(1000, "s5a");
    repeat ($urandom_range(3, 12)) @(negedge clk);
    push_frame(1, 1'b0);
    refresh = 1'b1;
    msg = 3'd1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done(1000, "s5b");
    repeat (200) @(negedge clk);
    check("s5_no_extra_frames", act_done, exp_done);
    check("s5_queue_empty", exp_q.size(), 0);

    // Asynchronous reset while EN is high, then out-of-range message
    push_frame(1, 1'b0);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    base = nbytes;
    wait_bytes(base + 10, 1000, "s6");
    #2 rst = 1'b1;
    #1;
    check("async_rst_en", lcd_en, 0);
    check("async_rst_data", lcd_data, 0);
    check("async_rst_busy", busy, 1);
    check("async_rst_done", frame_done, 0);
    exp_q.delete();
    exp_done--;
    msg = 3'd7;
    repeat (2) @(negedge clk);
    push_init();
    push_frame(7, 1'b1);
    rst = 1'b0;
    wait_done(2000, "s6");
    repeat (3) @(negedge clk);
    check("s6_first_en_cycle", first_en_cyc, PWRUP_CYC + 1);
    check("s6_frame_done_cycle", first_done_cyc, 306);
    check("s6_queue_empty", exp_q.size(), 0);
    check("total_frames", act_done, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_msg_ctrl.md
Name: lcd_msg_ctrl

Overview:
Self-contained HD44780 2x16 character LCD controller for the smart-watering display. It runs power-up and init, then shows one of NUM_MSG canned status messages selected by iMSG. The panel is rewritten only when the selection changes or a refresh is requested. It replaces the per-character register banks and the external reset-delay block with a timed FSM and an internal message ROM, and adds busy/done status.

Parameters:
NUM_MSG, 5, number of messages in ROM; MSG_W = max(1, clog2(NUM_MSG))
PWRUP_CYC, 750000, post-reset wait before first command (15 ms @ 50 MHz)
EN_CYC, 25, LCD_EN high time in cycles (500 ns)
CMD_CYC, 2500, post-EN wait for normal command/data bytes (50 us)
CLR_CYC, 100000, post-EN wait after Clear Display 0x01 (2 ms)

Ports:
iCLK  in  1  system clock, 50 MHz
iRST  in  1  asynchronous, active-high reset
iMSG  in  MSG_W  message select; 0 HUM OK/LUZ OK, 1 OK/LOW, 2 LOW/OK, 3 LOW/LOW, 4 WARNING
iREFRESH  in  1  single-cycle pulse; forces a rewrite of the current message
LCD_DATA  out  8  LCD data bus (write-only)
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  tied 0 (write)
LCD_EN  out  1  LCD enable strobe
oBUSY  out  1  high unless idle with nothing pending
oFRAME_DONE  out  1  one-cycle pulse when a full frame has been written

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transfer):
  - LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, oBUSY=1, oFRAME_DONE=0.
  - FSM returns to PWRUP; pending flag is set.
- Top FSM: PWRUP -> INIT -> FRAME -> IDLE, then IDLE <-> FRAME.
  - PWRUP: counts PWRUP_CYC cycles after reset release, then goes to INIT.
  - INIT: issues 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order, RS=0.
  - FRAME: 34 transactions in order:
    - 0x80 (RS=0)
    - 16 chars of row 0 (RS=1), col 0..15
    - 0xC0 (RS=0)
    - 16 chars of row 1 (RS=1)
  - IDLE: LCD_EN=0; LCD_DATA and LCD_RS keep their last values.
- Byte sub-FSM: SETUP -> EN_HI -> WAIT.
  - SETUP: 1 cycle; DATA and RS driven, EN=0.
  - EN_HI: exactly EN_CYC cycles with EN=1.
  - WAIT: CMD_CYC cycles, or CLR_CYC if the byte is command 0x01; EN=0.
  - DATA and RS stay stable from SETUP until the next SETUP.
  - Byte time = 1+EN_CYC+CMD_CYC (clear: 1+EN_CYC+CLR_CYC).
- Message latch:
  - iMSG is captured into shown_msg in the first SETUP of FRAME.
  - All 32 chars of a frame come from shown_msg, so there is no tearing.
- Pending flag:
  - Set when iREFRESH=1, or when iMSG != shown_msg in any state after INIT.
  - Cleared on frame start.
  - Refresh and change in the same cycle, or repeated requests during a frame, produce one follow-up frame after the current one. No frame is aborted.
  - The first frame after INIT always runs.
- IDLE with pending=1 starts FRAME on the next cycle.
- oFRAME_DONE pulses in the last WAIT cycle of byte 34.
  - oBUSY drops the following cycle if nothing is pending; otherwise it stays 1.
- iMSG >= NUM_MSG: ROM returns 0x20 (space) for all 32 chars.
- ROM rows, space-padded to 16 chars:
  - " HUMEDAD: OK"/" HUMEDAD: LOW" on row 0
  - " LUZ: OK"/" LUZ: LOW" on row 1, per index 0..3
  - Index 4: "     WARNING" / "      !!!!".
- Counters are sized to clog2 of the largest cycle parameter; none wrap in normal use.

Decomposition:
- Package lcd_pkg holds:
  - init command array and INIT_LEN=6
  - LCD_CMD_CLEAR=8'h01, LCD_ADDR_ROW0=8'h80, LCD_ADDR_ROW1=8'hC0
  - LCD_COLS=16, LCD_ROWS=2, ASCII_SPACE=8'h20
  - FSM state enums
- Sub-module lcd_msg_rom: combinational, inputs (msg, row, col), output 8-bit char, with the out-of-range -> space rule.

Test Plan:
All scenarios use PWRUP_CYC=20, EN_CYC=2, CMD_CYC=4, CLR_CYC=10.
1. Release reset, hold iMSG=0 -> first EN rise at cycle 21. Six INIT bytes in order 38,38,38,0C,01,06; each EN high exactly 2 cycles; 0x01 followed by a 10-cycle gap.
2. Continue scenario 1 -> bytes 80, " HUMEDAD: OK    ", C0, " LUZ: OK        " with RS pattern 0,1x16,0,1x16. oFRAME_DONE pulses once at cycle 306. oBUSY=0 from cycle 307.
3. In IDLE set iMSG=4 -> new frame starts next cycle. Row 0 "     WARNING    ", row 1 "      !!!!      ", no INIT bytes.
4. Mid-frame (char 5) switch iMSG 0->2, then 2->3 -> current frame completes with message 0 text. Exactly one further frame follows, showing LOW/LOW.
5. iREFRESH pulse in IDLE with iMSG unchanged, then iREFRESH and an iMSG change in the same cycle -> each event yields exactly one frame, i.e. 2 oFRAME_DONE pulses in total.
6. Assert iRST while EN=1 mid-frame -> EN=0, DATA=00, oBUSY=1 combinationally. After release the full PWRUP+INIT+frame sequence repeats. iMSG=7 gives 32 spaces.
